// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op and state encodings shared by the multiply/divide unit
package muldiv_pkg;
    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_RUN  = 2'b01,
        MD_FIX  = 2'b10,
        MD_DONE = 2'b11
    } md_state_t;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction
endpackage

// File: rtl/md_iter_core.sv
// md_iter_core: one shift-add multiply step or one restoring divide step
module md_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic               div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   rem,
    input  logic [WIDTH-1:0]   m,
    output logic [2*WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0]   rem_next
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] sh;
    logic [WIDTH:0] diff;

    // multiply: add multiplicand into the upper half when the low bit is set, then shift right;
    // divide: shift the next dividend bit into the remainder and keep the difference when no borrow
    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, m};
        sh       = {rem, acc[WIDTH-1]};
        diff     = sh - {1'b0, m};
        acc_next = div ? {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], ~diff[WIDTH]}
                 : acc[0] ? {sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
        rem_next = div ? (diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0]) : rem;
    end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle MULT/MULTU/DIV/DIVU engine producing HI/LO with a pipeline stall
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int FAST_MUL = 0,
    parameter int CNT_W    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             result_valid,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    md_state_t state;
    md_state_t state_nxt;
    logic [CNT_W-1:0] cnt;
    logic is_div;
    logic neg_q;
    logic neg_r;
    logic accept;
    logic op_div;
    logic direct;
    logic a_neg;
    logic b_neg;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;

    md_iter_core #(.WIDTH(WIDTH)) core (
        .div      (is_div),
        .acc      (acc),
        .rem      (rem),
        .m        (m),
        .acc_next (acc_step),
        .rem_next (rem_step)
    );

    // operand magnitudes, sign correction of the finished result, and next-state selection
    always_comb begin
        op_div    = op_is_div(op);
        a_neg     = op_is_signed(op) & a[WIDTH-1];
        b_neg     = op_is_signed(op) & b[WIDTH-1];
        a_abs     = a_neg ? -a : a;
        b_abs     = b_neg ? -b : b;
        prod      = {{WIDTH{1'b0}}, a_abs} * {{WIDTH{1'b0}}, b_abs};
        direct    = (FAST_MUL != 0) & ~op_div;
        accept    = start & ~flush & (state == MD_IDLE | state == MD_DONE);
        prod_fix  = neg_q ? -acc : acc;
        quo_fix   = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix   = neg_r ? -rem : rem;
        state_nxt = flush ? MD_IDLE
                  : accept ? (direct ? MD_FIX : MD_RUN)
                  : state == MD_RUN ? (cnt == CNT_W'(WIDTH - 1) ? MD_FIX : MD_RUN)
                  : state == MD_FIX ? MD_DONE : MD_IDLE;
    end

    assign busy         = state == MD_RUN | state == MD_FIX;
    assign stall        = accept | busy;
    assign result_valid = state == MD_DONE;

    // state register, operand capture on accept, one iteration per RUN cycle, HI/LO written in FIX
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= MD_IDLE;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            m      <= '0;
            rem    <= '0;
            acc    <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (state == MD_RUN && !flush) ? cnt + 1'b1 : '0;
            if (accept) begin
                is_div <= op_div;
                neg_q  <= op_div ? (a_neg ^ b_neg) & (|b) : a_neg ^ b_neg;
                neg_r  <= a_neg;
                m      <= op_div ? b_abs : a_abs;
                rem    <= '0;
                acc    <= op_div ? {{WIDTH{1'b0}}, a_abs} : direct ? prod : {{WIDTH{1'b0}}, b_abs};
            end else if (state == MD_RUN) begin
                acc <= acc_step;
                rem <= rem_step;
            end
            if (state == MD_FIX && !flush) begin
                hi <= is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
                lo <= is_div ? quo_fix : prod_fix[WIDTH-1:0];
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed checks of the iterative 32-bit unit and the 8-bit fast-multiply unit
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst, start, flush;
    logic [1:0] op;
    logic [W-1:0] a, b, hi, lo;
    logic busy, stall, rv;
    logic rst8, start8, flush8;
    logic [1:0] op8;
    logic [7:0] a8, b8, hi8, lo8;
    logic busy8, stall8, rv8;
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int rv_count = 0;
    int rv8_count = 0;

    muldiv_unit #(.WIDTH(W), .FAST_MUL(0)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
        .busy(busy), .stall(stall), .result_valid(rv), .hi(hi), .lo(lo)
    );

    muldiv_unit #(.WIDTH(8), .FAST_MUL(1)) dut8 (
        .clk(clk), .rst(rst8), .start(start8), .op(op8), .a(a8), .b(b8), .flush(flush8),
        .busy(busy8), .stall(stall8), .result_valid(rv8), .hi(hi8), .lo(lo8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rv) rv_count <= rv_count + 1;
        if (rv8) rv8_count <= rv8_count + 1;
    end

    task automatic wait_done(output int lat, output int stall_low);
        int s;
        s = cyc;
        lat = -1;
        stall_low = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            @(negedge clk);
            if (rv) begin
                lat = cyc - s;
                break;
            end
            if (!stall) stall_low++;
        end
    endtask

    task automatic do_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         output int lat, output int stall_low);
        int c0;
        @(posedge clk);
        #1;
        op = o;
        a = x;
        b = y;
        start = 1'b1;
        #1;
        c0 = stall ? 0 : 1;
        wait_done(lat, stall_low);
        stall_low += c0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rst8 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        rst8 = 1'b0;
        @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++; if (rv !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", rv); end
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b want 0", stall); end
        tests++; if (hi !== '0 || lo !== '0) begin fails++; $display("FAIL reset_hilo: got %h/%h want 0/0", hi, lo); end
        tests++; if (hi8 !== 8'h0 || lo8 !== 8'h0 || rv8 !== 1'b0) begin fails++; $display("FAIL reset_8: got %h/%h rv=%b want 00/00 rv=0", hi8, lo8, rv8); end
    endtask

    task automatic run_table(input string tag, input md_op_t ops[5], input logic [W-1:0] xa[5],
                             input logic [W-1:0] xb[5], input logic [W-1:0] eh[5],
                             input logic [W-1:0] el[5], input int n);
        int lat, sl;
        for (int i = 0; i < n; i++) begin
            do_op(ops[i], xa[i], xb[i], lat, sl);
            tests++; if (lat !== W + 2) begin fails++; $display("FAIL %s%0d_latency: got %0d want %0d", tag, i, lat, W + 2); end
            tests++; if (hi !== eh[i]) begin fails++; $display("FAIL %s%0d_hi: got %h want %h", tag, i, hi, eh[i]); end
            tests++; if (lo !== el[i]) begin fails++; $display("FAIL %s%0d_lo: got %h want %h", tag, i, lo, el[i]); end
            tests++; if (sl !== 0 || stall !== 1'b0) begin fails++; $display("FAIL %s%0d_stall: got %0d low cycles, done stall=%b want 0, 0", tag, i, sl, stall); end
        end
    endtask

    task automatic test_mult;
        md_op_t ops[5] = '{MD_MULT, MD_MULTU, MD_MULT, MD_MULT, MD_MULT};
        logic [W-1:0] xa[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00001000, 32'h0, 32'h0};
        logic [W-1:0] xb[5] = '{32'h00000002, 32'h00000002, 32'hFFFFFFFD, 32'h0, 32'h0};
        logic [W-1:0] eh[5] = '{32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'h0, 32'h0};
        logic [W-1:0] el[5] = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFD000, 32'h0, 32'h0};
        run_table("mul", ops, xa, xb, eh, el, 3);
    endtask

    task automatic test_div;
        md_op_t ops[5] = '{MD_DIV, MD_DIVU, MD_DIV, MD_DIVU, MD_DIV};
        logic [W-1:0] xa[5] = '{32'hFFFFFFF9, 32'h7, 32'h80000000, 32'h1234, 32'hFFFFFFF9};
        logic [W-1:0] xb[5] = '{32'h2, 32'h2, 32'hFFFFFFFF, 32'h0, 32'h0};
        logic [W-1:0] eh[5] = '{32'hFFFFFFFF, 32'h1, 32'h0, 32'h1234, 32'hFFFFFFF9};
        logic [W-1:0] el[5] = '{32'hFFFFFFFD, 32'h3, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        run_table("div", ops, xa, xb, eh, el, 5);
    endtask

    task automatic test_flush;
        int lat, sl, n0;
        do_op(MD_DIVU, 32'd7, 32'd2, lat, sl);
        @(posedge clk);
        #1;
        n0 = rv_count;
        op = MD_DIV;
        a = 32'd100;
        b = 32'd7;
        start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL flush_busy_before: got %b want 1", busy); end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        tests++; if (busy !== 1'b0 || stall !== 1'b0) begin fails++; $display("FAIL flush_busy_after: got busy=%b stall=%b want 0 0", busy, stall); end
        repeat (40) @(negedge clk);
        tests++; if (rv_count !== n0) begin fails++; $display("FAIL flush_no_valid: got %0d pulses want 0", rv_count - n0); end
        tests++; if (hi !== 32'h1 || lo !== 32'h3) begin fails++; $display("FAIL flush_hilo_kept: got %h/%h want 00000001/00000003", hi, lo); end
    endtask

    task automatic test_start_held;
        int n0;
        @(posedge clk);
        #1;
        n0 = rv_count;
        op = MD_DIVU;
        a = 32'd100;
        b = 32'd7;
        start = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        a = 32'd5;
        b = 32'd1;
        repeat (5) @(posedge clk);
        #1;
        start = 1'b0;
        repeat (30) @(negedge clk);
        tests++; if (rv_count - n0 !== 1) begin fails++; $display("FAIL held_one_result: got %0d pulses want 1", rv_count - n0); end
        tests++; if (hi !== 32'd2 || lo !== 32'd14) begin fails++; $display("FAIL held_result: got %h/%h want 00000002/0000000e", hi, lo); end
    endtask

    task automatic test_back_to_back;
        int lat, sl;
        do_op(MD_MULTU, 32'd3, 32'd5, lat, sl);
        tests++; if (lat !== W + 2 || hi !== 32'h0 || lo !== 32'd15) begin fails++; $display("FAIL b2b_first: got lat=%0d %h/%h want %0d 00000000/0000000f", lat, hi, lo, W + 2); end
        op = MD_DIV;
        a = 32'hFFFFFF9C;
        b = 32'd7;
        start = 1'b1;
        #1;
        tests++; if (stall !== 1'b1 || rv !== 1'b1) begin fails++; $display("FAIL b2b_accept_cycle: got stall=%b valid=%b want 1 1", stall, rv); end
        wait_done(lat, sl);
        tests++; if (lat !== W + 2) begin fails++; $display("FAIL b2b_latency: got %0d want %0d", lat, W + 2); end
        tests++; if (hi !== 32'hFFFFFFFE || lo !== 32'hFFFFFFF2) begin fails++; $display("FAIL b2b_result: got %h/%h want fffffffe/fffffff2", hi, lo); end
        tests++; if (sl !== 0) begin fails++; $display("FAIL b2b_stall: got %0d low cycles want 0", sl); end
    endtask

    task automatic test_fast_mul;
        logic [1:0] fo[2] = '{2'b00, 2'b01};
        logic [7:0] fa[2] = '{8'h80, 8'hFF};
        logic [7:0] fb[2] = '{8'h80, 8'hFF};
        logic [7:0] fh[2] = '{8'h40, 8'hFE};
        logic [7:0] fl[2] = '{8'h00, 8'h01};
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            op8 = fo[i];
            a8 = fa[i];
            b8 = fb[i];
            start8 = 1'b1;
            @(negedge clk);
            tests++; if (stall8 !== 1'b1 || rv8 !== 1'b0) begin fails++; $display("FAIL fast%0d_cycle0: got stall=%b valid=%b want 1 0", i, stall8, rv8); end
            @(posedge clk);
            #1;
            start8 = 1'b0;
            @(negedge clk);
            tests++; if (busy8 !== 1'b1 || rv8 !== 1'b0) begin fails++; $display("FAIL fast%0d_cycle1: got busy=%b valid=%b want 1 0", i, busy8, rv8); end
            @(negedge clk);
            tests++; if (rv8 !== 1'b1) begin fails++; $display("FAIL fast%0d_valid: got %b want 1", i, rv8); end
            tests++; if (hi8 !== fh[i] || lo8 !== fl[i]) begin fails++; $display("FAIL fast%0d_result: got %h/%h want %h/%h", i, hi8, lo8, fh[i], fl[i]); end
        end
    endtask

    task automatic test_fast_reset;
        int n0;
        @(posedge clk);
        #1;
        n0 = rv8_count;
        op8 = MD_MULT;
        a8 = 8'h7F;
        b8 = 8'h03;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        rst8 = 1'b1;
        @(posedge clk);
        #1;
        rst8 = 1'b0;
        @(negedge clk);
        tests++; if (rv8 !== 1'b0 || busy8 !== 1'b0) begin fails++; $display("FAIL fast_rst_state: got valid=%b busy=%b want 0 0", rv8, busy8); end
        tests++; if (hi8 !== 8'h0 || lo8 !== 8'h0) begin fails++; $display("FAIL fast_rst_hilo: got %h/%h want 00/00", hi8, lo8); end
        repeat (4) @(negedge clk);
        tests++; if (rv8_count !== n0) begin fails++; $display("FAIL fast_rst_no_valid: got %0d pulses want 0", rv8_count - n0); end
    endtask

    initial begin
        start = 1'b0;
        flush = 1'b0;
        op = 2'b00;
        a = '0;
        b = '0;
        start8 = 1'b0;
        flush8 = 1'b0;
        op8 = 2'b00;
        a8 = '0;
        b8 = '0;
        test_reset;
        test_mult;
        test_div;
        test_flush;
        test_start_held;
        test_back_to_back;
        test_fast_mul;
        test_fast_reset;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
